// File: rtl/target_port.sv
`default_nettype none
// ============================================================================
// target_port : serial-bus target responder; deserializes address/data,
//               decodes device ID, handshakes with local memory, serializes reads
// Revision    : 1.0
// ============================================================================
module target_port #(
  parameter logic [3:0] DEVICE_ID     = 4'h1,
  parameter int         SPLIT_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_data_in,
  input  logic        bus_data_in_valid,
  input  logic        bus_mode,
  input  logic        bus_init_rw,
  input  logic        bus_init_ready,
  output logic        bus_data_out,
  output logic        bus_data_out_valid,
  output logic        target_ack,
  output logic        target_split,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy
);

  localparam logic [15:0] C_SPLIT_LIMIT = 16'(SPLIT_TIMEOUT);
  localparam logic        C_SPLIT_EN    = (SPLIT_TIMEOUT != 0);

  typedef enum logic [2:0] {
    ST_RX_ADDR  = 3'd0,
    ST_RX_DATA  = 3'd1,
    ST_WR_LOCAL = 3'd2,
    ST_RD_LOCAL = 3'd3,
    ST_TX_DATA  = 3'd4
  } state_t;

  state_t      r_state, w_state_n;
  logic [14:0] r_addr_sr, w_addr_sr_n;
  logic [3:0]  r_addr_cnt, w_addr_cnt_n;
  logic [6:0]  r_data_sr, w_data_sr_n;
  logic [2:0]  r_data_cnt, w_data_cnt_n;
  logic [2:0]  r_tx_cnt, w_tx_cnt_n;
  logic [15:0] r_wait_cnt, w_wait_cnt_n;
  logic        r_split_done, w_split_done_n;
  logic [7:0]  r_rbyte, w_rbyte_n;

  logic [11:0] w_mem_addr_n;
  logic [7:0]  w_mem_wdata_n;
  logic        w_mem_we_n, w_mem_re_n;
  logic        w_dout_n, w_dout_valid_n, w_ack_n, w_split_n, w_busy_n;
  logic [3:0]  w_dev_id;
  logic        w_split_hit;

  // Only the top nibble matters for decode; the last bit arrives on the bus itself.
  assign w_dev_id    = {bus_data_in, r_addr_sr[14:12]};
  assign w_split_hit = C_SPLIT_EN && !r_split_done && ((r_wait_cnt + 16'd1) == C_SPLIT_LIMIT);

  always_comb begin
    w_state_n      = r_state;
    w_addr_sr_n    = r_addr_sr;
    w_addr_cnt_n   = r_addr_cnt;
    w_data_sr_n    = r_data_sr;
    w_data_cnt_n   = r_data_cnt;
    w_tx_cnt_n     = r_tx_cnt;
    w_wait_cnt_n   = r_wait_cnt;
    w_split_done_n = r_split_done;
    w_rbyte_n      = r_rbyte;
    w_mem_addr_n   = mem_addr;
    w_mem_wdata_n  = mem_wdata;
    w_mem_we_n     = mem_we;
    w_mem_re_n     = mem_re;
    w_dout_n       = bus_data_out;
    w_dout_valid_n = 1'b0;
    w_ack_n        = 1'b0;
    w_split_n      = 1'b0;

    case (r_state)
      ST_RX_ADDR: begin
        if (bus_data_in_valid && !bus_mode) begin
          if (r_addr_cnt == 4'd15) begin
            w_addr_cnt_n = 4'd0;
            if (w_dev_id == DEVICE_ID) begin
              if (bus_init_rw) begin
                w_state_n    = ST_RX_DATA;
                w_data_cnt_n = 3'd0;
              end else begin
                w_state_n      = ST_RD_LOCAL;
                w_mem_re_n     = 1'b1;
                w_mem_addr_n   = r_addr_sr[11:0];
                w_wait_cnt_n   = 16'd0;
                w_split_done_n = 1'b0;
              end
            end
          end else begin
            // LSB-first: after 15 shifts bit n sits at position n.
            w_addr_sr_n  = {bus_data_in, r_addr_sr[14:1]};
            w_addr_cnt_n = r_addr_cnt + 4'd1;
          end
        end
      end

      ST_RX_DATA: begin
        if (bus_data_in_valid) begin
          if (bus_mode) begin
            if (r_data_cnt == 3'd7) begin
              w_state_n     = ST_WR_LOCAL;
              w_mem_we_n    = 1'b1;
              w_mem_wdata_n = {bus_data_in, r_data_sr};
              w_mem_addr_n  = r_addr_sr[11:0];
              w_data_cnt_n  = 3'd0;
            end else begin
              w_data_sr_n  = {bus_data_in, r_data_sr[6:1]};
              w_data_cnt_n = r_data_cnt + 3'd1;
            end
          end else begin
            // Abort: this address bit starts a fresh address.
            w_state_n    = ST_RX_ADDR;
            w_addr_sr_n  = {bus_data_in, r_addr_sr[14:1]};
            w_addr_cnt_n = 4'd1;
            w_data_cnt_n = 3'd0;
          end
        end
      end

      ST_WR_LOCAL: begin
        if (mem_we && mem_ready) begin
          w_mem_we_n = 1'b0;
          w_ack_n    = 1'b1;
          w_state_n  = ST_RX_ADDR;
        end
      end

      ST_RD_LOCAL: begin
        if (mem_rvalid) begin
          w_rbyte_n    = mem_rdata;
          w_mem_re_n   = 1'b0;
          w_state_n    = ST_TX_DATA;
          w_wait_cnt_n = 16'd0;
          if (bus_init_ready) begin
            w_dout_n       = mem_rdata[0];
            w_dout_valid_n = 1'b1;
            w_tx_cnt_n     = 3'd1;
          end else begin
            w_tx_cnt_n = 3'd0;
          end
        end else begin
          if (r_wait_cnt != 16'hFFFF) begin
            w_wait_cnt_n = r_wait_cnt + 16'd1;
          end
          if (w_split_hit) begin
            w_split_n      = 1'b1;
            w_split_done_n = 1'b1;
          end
        end
      end

      ST_TX_DATA: begin
        if (bus_init_ready) begin
          w_dout_n       = r_rbyte[r_tx_cnt];
          w_dout_valid_n = 1'b1;
          if (r_tx_cnt == 3'd7) begin
            w_ack_n    = 1'b1;
            w_state_n  = ST_RX_ADDR;
            w_tx_cnt_n = 3'd0;
          end else begin
            w_tx_cnt_n = r_tx_cnt + 3'd1;
          end
        end
      end

      default: begin
        w_state_n = ST_RX_ADDR;
      end
    endcase

    w_busy_n = (w_state_n != ST_RX_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= ST_RX_ADDR;
      r_addr_sr          <= '0;
      r_addr_cnt         <= '0;
      r_data_sr          <= '0;
      r_data_cnt         <= '0;
      r_tx_cnt           <= '0;
      r_wait_cnt         <= '0;
      r_split_done       <= 1'b0;
      r_rbyte            <= '0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_we             <= 1'b0;
      mem_re             <= 1'b0;
      bus_data_out       <= 1'b0;
      bus_data_out_valid <= 1'b0;
      target_ack         <= 1'b0;
      target_split       <= 1'b0;
      busy               <= 1'b0;
    end else begin
      r_state            <= w_state_n;
      r_addr_sr          <= w_addr_sr_n;
      r_addr_cnt         <= w_addr_cnt_n;
      r_data_sr          <= w_data_sr_n;
      r_data_cnt         <= w_data_cnt_n;
      r_tx_cnt           <= w_tx_cnt_n;
      r_wait_cnt         <= w_wait_cnt_n;
      r_split_done       <= w_split_done_n;
      r_rbyte            <= w_rbyte_n;
      mem_addr           <= w_mem_addr_n;
      mem_wdata          <= w_mem_wdata_n;
      mem_we             <= w_mem_we_n;
      mem_re             <= w_mem_re_n;
      bus_data_out       <= w_dout_n;
      bus_data_out_valid <= w_dout_valid_n;
      target_ack         <= w_ack_n;
      target_split       <= w_split_n;
      busy               <= w_busy_n;
    end
  end

endmodule
`default_nettype wire
